team_06_pwm_dac: RTL and testbench
==================================

# team_06_pwm_dac

Audio output stage for the effects chain. Accepts 8-bit unsigned samples from the soft clipper (`soft_out`) through a valid/ready handshake and holds them in a one-entry buffer. Each sample drives one PWM frame on a single output pin for an external RC filter, so the output runs at the frame rate. Missed samples are flagged, and the previous duty is repeated.

## Interface
- `PRESCALE`, default 1: clock cycles per PWM count (≥1). A frame lasts 256·PRESCALE cycles.
- `clk` in 1: system clock.
- `nrst` in 1: asynchronous reset, active-low.
- `en` in 1: output enable. Low forces idle.
- `sample_in` in 8: unsigned sample, 0–255.
- `sample_valid` in 1: `sample_in` is valid.
- `sample_ready` out 1: the buffer can take a sample.
- `pwm_out` out 1: registered PWM output.
- `frame_start` out 1: one-cycle pulse on the first cycle of each frame.
- `underrun` out 1: one-cycle pulse when a frame starts with an empty buffer.

## Operation
- Reset values:
  - `pwm_out`=0, `sample_ready`=1, `frame_start`=0, `underrun`=0.
  - Internal: count=0, duty=0, prescale=0, hold empty, state IDLE.
- Hold buffer:
  - `sample_ready` = !hold_full.
  - Accept when `sample_valid` && `sample_ready`. hold_full is set on that edge.
  - Accepting is independent of state, including in IDLE.
- Tick: the prescaler pulses `tick` every PRESCALE cycles. It is cleared to 0 whenever state ≠ RUN.
- FSM states:
  - **IDLE:** `pwm_out`=0, count=0. Go to PRIME when `en`=1.
  - **PRIME:** `pwm_out`=0. Wait for hold_full. On that edge: duty ← hold, hold emptied, count=0, go to RUN, `frame_start` pulses the next cycle. If `en`=0, go to IDLE.
  - **RUN:** count increments on each `tick`, wrapping 255→0.
    - `pwm_out` ← (count < duty).
    - If `en`=0, go to IDLE at once, even mid-frame. `pwm_out`=0 from the next cycle; hold contents are kept.
- Frame boundary (RUN, `tick` && count==255), on that edge:
  - count → 0.
  - If hold_full: duty ← hold and hold emptied.
  - If hold empty: duty unchanged, and `underrun` pulses the next cycle.
  - `frame_start` pulses the next cycle.
- Simultaneous boundary with an empty hold and an accept in the same cycle: `underrun` still pulses and duty repeats. The new sample lands in hold and is used at the following boundary.
- Duty extremes:
  - duty 0 → `pwm_out` never high.
  - duty 255 → high for 255 counts, low for 1.
- Arithmetic: unsigned 8-bit compare. No sign conversion; the upstream stage delivers offset-binary.

## Timing
- `pwm_out` is registered. For a count value c, `pwm_out` reflects c < duty during the PRESCALE cycles that follow the edge where count became c.
- Latency:
  - A sample accepted while RUN is output starting at the next frame boundary, at most 256·PRESCALE+1 cycles later.
  - In PRIME: accept at edge t, duty loaded at edge t+1, `pwm_out` first high after edge t+2.
- Throughput: one sample per frame. `sample_ready` falls on the accept edge and rises on the load edge.
- `nrst` asserted mid-frame: all state returns to reset values asynchronously, and any buffered sample is discarded.

## Structure
- `team_06_pkg`: `pwm_state_t` enum {IDLE, PRIME, RUN}, `AUDIO_W`=8, `PWM_MAX`=8'd255.
- Sub-module `team_06_pwm_prescaler`: a counter 0..PRESCALE-1 with a synchronous clear, producing `tick`. With PRESCALE=1, `tick` is constant 1 while enabled.
- Top level: FSM, hold register, duty register, count register, and the output compare.

## Test plan
1. **Reset:** assert `nrst`=0 mid-frame with PRESCALE=1 → `pwm_out`=0, `sample_ready`=1, and no pulses. Release → module sits in IDLE.
2. **Basic frame:** PRESCALE=1, `en`=1, send 64 → after PRIME, `pwm_out` is high for 64 cycles then low for 192. `frame_start` occurs every 256 cycles.
3. **Extremes:** send 0 then 255 → frame 1 has zero high cycles. Frame 2 has 255 high cycles then 1 low.
4. **Underrun:** send one sample (100), then no more → `underrun` pulses at every boundary, and each frame stays at 100 high cycles.
5. **Backpressure:** hold `sample_valid` high with 10, then 20 → `sample_ready` drops after 10 is accepted. 20 is accepted the cycle after the next boundary, and frames play 10 then 20.
6. **Enable drop with PRESCALE=4:** set `en`=0 at count 50 with one sample held → `pwm_out`=0 next cycle and state is IDLE. Re-enable → PRIME loads the held sample, and a frame lasts 1024 cycles.

Source files
------------

// File: rtl/team_06_pkg.sv
// team_06_pkg
// Shared types and constants for the PWM audio DAC.
//   pwm_state_t : output FSM states (IDLE, PRIME, RUN)
//   AUDIO_W     : sample / duty / count width
//   PWM_MAX     : last count of a PWM frame
package team_06_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pwm_state_t;

  localparam int             AUDIO_W = 8;
  localparam logic [AUDIO_W-1:0] PWM_MAX = 8'd255;

endpackage

// File: rtl/team_06_pwm_prescaler.sv
// team_06_pwm_prescaler
// Divides the system clock into PWM count ticks.
//   clk   : system clock
//   nrst  : asynchronous reset, active-low
//   clr   : synchronous clear; holds the divider at 0 and suppresses tick
//   tick  : high for one cycle every PRESCALE cycles while not cleared
//           (constantly high when PRESCALE is 1)
module team_06_pwm_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] div_cnt;

  assign tick = !clr && (div_cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_cnt <= '0;
    end else if (clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/team_06_pwm_dac.sv
// team_06_pwm_dac
// One-bit PWM audio output. Each accepted 8-bit unsigned sample becomes
// the duty of one 256-count frame; a frame lasts 256*PRESCALE cycles.
// A one-entry hold buffer decouples the upstream handshake from frames;
// when a frame starts with the buffer empty the previous duty repeats
// and underrun pulses.
//   clk          : system clock
//   nrst         : asynchronous reset, active-low
//   en           : output enable, low forces idle (buffer contents kept)
//   sample_in    : unsigned sample
//   sample_valid : sample_in is valid
//   sample_ready : hold buffer is empty and can take a sample
//   pwm_out      : registered PWM output
//   frame_start  : one-cycle pulse on the first cycle of each frame
//   underrun     : one-cycle pulse when a frame starts with an empty buffer
module team_06_pwm_dac
  import team_06_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic [AUDIO_W-1:0] sample_in,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               pwm_out,
  output logic               frame_start,
  output logic               underrun
);

  pwm_state_t         state, state_nxt;
  logic [AUDIO_W-1:0] hold, duty, count;
  logic               hold_full;
  logic               tick, presc_clr;
  logic               accept, prime_load, boundary, load;

  assign presc_clr = (state != RUN);

  team_06_pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .nrst (nrst),
    .clr  (presc_clr),
    .tick (tick)
  );

  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;

  // Enable is checked first everywhere: a drop wins over a pending load.
  assign prime_load = (state == PRIME) && en && hold_full;
  assign boundary   = (state == RUN) && en && tick && (count == PWM_MAX);
  assign load       = prime_load || (boundary && hold_full);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = PRIME;
      PRIME:   if (!en) state_nxt = IDLE;
               else if (hold_full) state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load and accept are mutually exclusive: load needs a full buffer,
  // accept needs an empty one, so a boundary with an empty buffer can
  // take a new sample that is then used one frame later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      duty      <= '0;
    end else begin
      if (load) begin
        duty      <= hold;
        hold_full <= 1'b0;
      end else if (accept) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end
    end
  end

  // Count wraps 255 -> 0 by natural overflow at the frame boundary.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if ((state != RUN) || !en) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  // Output register stage: compare of the current count against duty.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      pwm_out     <= (state == RUN) && en && (count < duty);
      frame_start <= prime_load || boundary;
      underrun    <= boundary && !hold_full;
    end
  end

endmodule

// File: tb/tb_team_06_pwm_dac.sv
// tb_team_06_pwm_dac
// Drives two DAC instances (PRESCALE 1 and 4) from one stimulus stream.
// Each instance has a frame-level reference model that pushes the expected
// (duty, underrun) of every frame into a queue, and a monitor that pops it
// on frame_start and checks the PWM waveform cycle by cycle.
module tb_team_06_pwm_dac;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic       sample_valid;
  logic [7:0] sample_in;
  logic [1:0] ready_v, pwm_v, fs_v, ur_v;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int duty;
    bit under;
  } exp_t;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int p, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s prescale=%0d t=%0t got=%0d want=%0d", name, p, $time, got, want);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int P = (gi == 0) ? 1 : 4;

    team_06_pwm_dac #(
      .PRESCALE (P)
    ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .en           (en),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (ready_v[gi]),
      .pwm_out      (pwm_v[gi]),
      .frame_start  (fs_v[gi]),
      .underrun     (ur_v[gi])
    );

    exp_t exp_q[$];
    int   m_mode;   // 0 off, 1 waiting for first sample, 2 playing
    int   m_duty;
    int   m_hold;
    int   m_cyc;    // cycles since the current frame began
    bit   m_full;

    initial begin : model
      bit   acc;
      exp_t e;
      m_mode = 0; m_duty = 0; m_hold = 0; m_cyc = 0; m_full = 0;
      forever begin
        @(posedge clk);
        if (!nrst) begin
          m_mode = 0; m_duty = 0; m_full = 0; m_cyc = 0;
          exp_q.delete();
        end else begin
          acc = sample_valid && !m_full;
          case (m_mode)
            0: if (en) m_mode = 1;
            1: begin
              if (!en) m_mode = 0;
              else if (m_full) begin
                m_duty = m_hold; m_full = 0; m_cyc = 0; m_mode = 2;
                e.duty = m_duty; e.under = 0;
                exp_q.push_back(e);
              end
            end
            default: begin
              if (!en) m_mode = 0;
              else begin
                m_cyc++;
                if (m_cyc == 256 * P) begin
                  m_cyc = 0;
                  if (m_full) begin
                    m_duty = m_hold; m_full = 0; e.under = 0;
                  end else begin
                    e.under = 1;
                  end
                  e.duty = m_duty;
                  exp_q.push_back(e);
                end
              end
            end
          endcase
          if (acc) begin
            m_hold = int'(sample_in);
            m_full = 1;
          end
        end
      end
    end

    initial begin : monitor
      int   k;
      int   cur;
      int   want;
      bit   active;
      exp_t e;
      k = 0; cur = 0; active = 0;
      forever begin
        @(negedge clk);
        if (!nrst) begin
          chk("reset_outputs", P, {pwm_v[gi], ready_v[gi], fs_v[gi], ur_v[gi]}, 4'b0100);
          active = 0;
        end else begin
          chk("sample_ready", P, ready_v[gi], !m_full);
          if (m_mode != 2) begin
            chk("pwm_idle", P, pwm_v[gi], 0);
            active = 0;
          end else if (active) begin
            k++;
            want = (((k - 1) / P) < cur) ? 1 : 0;
            chk("pwm", P, pwm_v[gi], want);
          end else begin
            chk("pwm_pre_frame", P, pwm_v[gi], 0);
          end
          chk("frame_start", P, fs_v[gi], exp_q.size());
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("underrun", P, ur_v[gi], e.under);
            cur = e.duty;
            active = 1;
            k = 0;
          end else begin
            chk("underrun_quiet", P, ur_v[gi], 0);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers a sample until the PRESCALE=1 instance takes it.
  task automatic send(input int v);
    int n;
    n = 0;
    sample_in    = 8'(v);
    sample_valid = 1'b1;
    @(negedge clk);
    while (!ready_v[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("send_accepted", 1, ready_v[0], 1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sample_in    = 8'($urandom);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_in = 8'd0;
    #1 nrst = 1'b0;
    cyc(3);
    nrst = 1'b1;
    cyc(4);

    // sample accepted while idle, then a plain frame followed by underruns
    send(64);
    en = 1'b1;
    cyc(600);

    // duty extremes
    send(0);
    send(255);
    cyc(600);

    // backpressure: second sample waits for the next boundary
    send(10);
    send(20);
    cyc(300);

    // reset in the middle of a frame
    nrst = 1'b0;
    cyc(3);
    nrst = 1'b1;
    cyc(5);

    // randomized samples, gaps and enable drops
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        en = 1'b0;
        cyc($urandom_range(1, 20));
        en = 1'b1;
      end
      send($urandom_range(0, 255));
      cyc($urandom_range(0, 300));
    end

    // enable drop mid-frame with a sample held, then resume
    send(200);
    cyc(50);
    en = 1'b0;
    cyc(20);
    en = 1'b1;
    cyc(1100);

    en = 1'b0;
    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
